uart_rx_buffered: RTL and testbench

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_byte_fifo.sv | 56 +++++
 rtl/uart_rx_buffered.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared types and constants for the buffered UART receiver.
//   rxState_t  - receiver FSM states
//   OVERSAMPLE - oversample ticks per bit
//   TICK_*     - tick numbers (1-based within a bit window) used for sampling
//   calcDiv()  - clocks per oversample tick, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rxState_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_EARLY = 7;
  localparam int unsigned TICK_MID   = 8;
  localparam int unsigned TICK_LATE  = 9;

  // round(clkFreq / (baud * OVERSAMPLE))
  function automatic int unsigned calcDiv(input int unsigned clkFreq, input int unsigned baud);
    int unsigned den;
    den = baud * OVERSAMPLE;
    return (clkFreq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
`timescale 1ns/1ps
// uart_byte_fifo: first-word-fall-through byte FIFO.
//   clk, rst_n - clock, async active-low reset
//   push, din  - write request and data (ignored when full unless popping)
//   pop        - read request (ignored when empty)
//   dout       - head byte
//   count      - bytes held; full / empty flags
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= din;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + CNT_W'(1);
      else if (!doPush && doPop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
`timescale 1ns/1ps
// uart_rx_buffered: 8N1 UART receiver with 16x oversampling, majority-vote
// bit decisions and a receive FIFO.
//   clk, rst_n  - clock, async active-low reset
//   RxD         - serial line (async, idles high, LSB first)
//   rd_en       - pop head byte
//   rd_data     - head byte (first-word-fall-through), rd_valid - FIFO not empty
//   fifo_count  - bytes held
//   framing_err - pulse: stop bit sampled low
//   overrun_err - pulse: byte completed with FIFO full and no pop
//   RxD_idle    - FSM idle and line high
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RxD,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        framing_err,
  output logic                        overrun_err,
  output logic                        RxD_idle
);

  localparam int unsigned DIV    = calcDiv(CLK_FREQ, BAUD);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  logic [1:0]        rxSync;
  logic              rxS;
  logic              rxPrev;
  logic [DIV_W-1:0]  divCnt;
  logic              tick;
  logic [TICK_W-1:0] tickCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic [1:0]        smpl;
  logic              armed;
  logic              hitEarly;
  logic              hitMid;
  logic              hitLate;
  logic              bitDone;
  logic              rxBit;
  rxState_t          state;
  rxState_t          stateNext;
  logic              startC;
  logic              pushC;
  logic              framingC;
  logic              fifoFull;
  logic              fifoEmpty;

  assign rxS  = rxSync[1];
  assign tick = (divCnt == DIV_W'(DIV - 1));

  // tickCnt holds ticks already elapsed in the window, so "tick n" fires when it reads n-1.
  assign hitEarly = tick && (tickCnt == TICK_W'(TICK_EARLY - 1));
  assign hitMid   = tick && (tickCnt == TICK_W'(TICK_MID - 1));
  assign hitLate  = tick && (tickCnt == TICK_W'(TICK_LATE - 1));
  // armed blocks the start window's leftover tick 9 right after entering DATA.
  assign bitDone  = hitLate && armed;
  assign rxBit    = (smpl[0] & smpl[1]) | (smpl[0] & rxS) | (smpl[1] & rxS);

  // Line synchronizer and edge-detect history; idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxSync <= 2'b11;
      rxPrev <= 1'b1;
    end else begin
      rxSync <= {rxSync[0], RxD};
      rxPrev <= rxS;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM next-state and push/error strobes.
  always_comb begin
    stateNext = state;
    startC    = 1'b0;
    pushC     = 1'b0;
    framingC  = 1'b0;
    case (state)
      IDLE: begin
        if (rxPrev && !rxS) begin
          stateNext = START;
          startC    = 1'b1;
        end
      end
      START: begin
        if (hitMid) stateNext = rxS ? IDLE : DATA;
      end
      DATA: begin
        if (bitDone && (bitIdx == 3'd7)) stateNext = STOP;
      end
      STOP: begin
        if (hitMid) begin
          if (rxS) begin
            pushC     = 1'b1;
            stateNext = IDLE;
          end else begin
            framingC  = 1'b1;
            stateNext = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Oversample timing, bit sampling and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt   <= '0;
      tickCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      smpl     <= '0;
      armed    <= 1'b0;
    end else begin
      if (startC) begin
        divCnt  <= '0;
        tickCnt <= '0;
      end else begin
        divCnt <= tick ? '0 : divCnt + DIV_W'(1);
        if (tick) tickCnt <= tickCnt + TICK_W'(1);
      end
      if ((state == START) && hitMid) begin
        bitIdx <= '0;
        armed  <= 1'b0;
      end
      if (state == DATA) begin
        if (hitEarly) begin
          smpl[0] <= rxS;
          armed   <= 1'b1;
        end
        if (hitMid) smpl[1] <= rxS;
        if (bitDone) begin
          shiftReg <= {rxBit, shiftReg[7:1]};
          bitIdx   <= bitIdx + 3'd1;
          armed    <= 1'b0;
        end
      end
    end
  end

  // Registered status outputs; RxD_idle looks ahead to next cycle's state/line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      RxD_idle    <= 1'b1;
    end else begin
      framing_err <= framingC;
      overrun_err <= pushC & fifoFull & ~rd_en;
      RxD_idle    <= (stateNext == IDLE) & rxSync[0];
    end
  end

  uart_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pushC),
    .pop  (rd_en),
    .din  (shiftReg),
    .dout (rd_data),
    .count(fifo_count),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  assign rd_valid = ~fifoEmpty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
`timescale 1ns/1ps
// Bench for uart_rx_buffered at 1.6 MHz / 10 kBd (DIV=10, 160 clocks per bit).
module tb_uart_rx_buffered;

  localparam int unsigned BIT_CLKS = 160;
  // Frame start negedge to push posedge: 2 sync + 1 detect + 152 ticks of 10 clocks.
  localparam int unsigned PUSH_NEG = 1522;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       framing_err;
  logic       overrun_err;
  logic       RxD_idle;

  int total = 0;
  int bad = 0;
  int framCnt = 0;
  int ovrCnt = 0;
  logic [7:0] expQ[$];

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         expCount;
    int         expFram;
  } vec_t;
  vec_t vecs[4];

  uart_rx_buffered #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .FIFO_DEPTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RxD        (RxD),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .RxD_idle   (RxD_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_err) framCnt++;
    if (overrun_err) ovrCnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RxD = stopBit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Pops the head and compares it with the scoreboard; call at a negedge.
  task automatic popCheck(input string name);
    logic [7:0] e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got pop want empty scoreboard", name);
      return;
    end
    e = expQ.pop_front();
    check({name, " valid"}, 32'(rd_valid), 32'd1);
    check({name, " data"}, 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check({name, " count"}, 32'(fifo_count), 32'(expQ.size()));
  endtask

  initial begin
    int fr0;
    int ov0;
    logic [7:0] b3c;

    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 2, 0};
    vecs[2] = '{8'hA5, 1'b0, 2, 1};
    vecs[3] = '{8'h81, 1'b1, 3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst valid", 32'(rd_valid), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst data", 32'(rd_data), 32'd0);
    check("rst ferr", 32'(framing_err), 32'd0);
    check("rst oerr", 32'(overrun_err), 32'd0);
    check("rst idle", 32'(RxD_idle), 32'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post rst idle", 32'(RxD_idle), 32'd1);

    // 0x55 with exact push latency
    fr0 = framCnt;
    ov0 = ovrCnt;
    fork
      sendByte(8'h55, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_NEG) @(negedge clk);
        check("lat pre valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("lat post valid", 32'(rd_valid), 32'd1);
        check("lat post data", 32'(rd_data), 32'h55);
      end
    join
    expQ.push_back(8'h55);
    repeat (4) @(negedge clk);
    check("55 count", 32'(fifo_count), 32'd1);
    check("55 ferr", 32'(framCnt - fr0), 32'd0);
    check("55 oerr", 32'(ovrCnt - ov0), 32'd0);
    popCheck("55 pop");

    // Table-driven frames accumulating in the FIFO
    for (int v = 0; v < 4; v++) begin
      fr0 = framCnt;
      ov0 = ovrCnt;
      sendByte(vecs[v].data, vecs[v].stopBit);
      if (vecs[v].stopBit) expQ.push_back(vecs[v].data);
      RxD = 1'b1;
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d count", v), 32'(fifo_count), 32'(vecs[v].expCount));
      check($sformatf("vec%0d ferr", v), 32'(framCnt - fr0), 32'(vecs[v].expFram));
      check($sformatf("vec%0d oerr", v), 32'(ovrCnt - ov0), 32'd0);
      check($sformatf("vec%0d head", v), 32'(rd_data), 32'(expQ[0]));
    end
    while (expQ.size() > 0) popCheck("vec drain");

    // Pops on an empty FIFO are ignored
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check("underflow count", 32'(fifo_count), 32'd0);
    check("underflow valid", 32'(rd_valid), 32'd0);

    // 100 ns glitch: false start, back to IDLE
    fr0 = framCnt;
    @(negedge clk);
    RxD = 1'b0;
    repeat (10) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch in start", 32'(RxD_idle), 32'd0);
    repeat (60) @(negedge clk);
    check("glitch idle", 32'(RxD_idle), 32'd1);
    check("glitch count", 32'(fifo_count), 32'd0);
    check("glitch ferr", 32'(framCnt - fr0), 32'd0);

    // 0xA5 with stop low, line held low afterwards
    fr0 = framCnt;
    sendByte(8'hA5, 1'b0);
    repeat (100) @(negedge clk);
    check("wh ferr", 32'(framCnt - fr0), 32'd1);
    check("wh count", 32'(fifo_count), 32'd0);
    check("wh idle low", 32'(RxD_idle), 32'd0);
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    check("wh idle high", 32'(RxD_idle), 32'd1);

    // Fill to 16, then 0x10 without a read overruns
    for (int i = 0; i < 16; i++) begin
      sendByte(8'(i), 1'b1);
      expQ.push_back(8'(i));
    end
    repeat (4) @(negedge clk);
    check("full count", 32'(fifo_count), 32'd16);
    check("full head", 32'(rd_data), 32'h00);
    ov0 = ovrCnt;
    sendByte(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr pulse", 32'(ovrCnt - ov0), 32'd1);
    check("ovr count", 32'(fifo_count), 32'd16);
    check("ovr head", 32'(rd_data), 32'h00);

    // 0x10 again with a pop in its push cycle
    ov0 = ovrCnt;
    fork
      sendByte(8'h10, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_NEG) @(negedge clk);
        check("simul pre count", 32'(fifo_count), 32'd16);
        check("simul pre head", 32'(rd_data), 32'(expQ[0]));
        void'(expQ.pop_front());
        expQ.push_back(8'h10);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("simul post count", 32'(fifo_count), 32'd16);
        check("simul post head", 32'(rd_data), 32'h01);
      end
    join
    repeat (4) @(negedge clk);
    check("simul oerr", 32'(ovrCnt - ov0), 32'd0);
    while (expQ.size() > 0) popCheck("full drain");

    // Reset during bit 4 of 0x3C, then 0xC3
    b3c = 8'h3C;
    fr0 = framCnt;
    ov0 = ovrCnt;
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = b3c[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RxD = b3c[4];
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst valid", 32'(rd_valid), 32'd0);
    check("midrst idle", 32'(RxD_idle), 32'd1);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("abandon count", 32'(fifo_count), 32'd0);
    check("abandon ferr", 32'(framCnt - fr0), 32'd0);
    check("abandon oerr", 32'(ovrCnt - ov0), 32'd0);
    sendByte(8'hC3, 1'b1);
    expQ.push_back(8'hC3);
    repeat (4) @(negedge clk);
    check("c3 count", 32'(fifo_count), 32'd1);
    popCheck("c3 pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
